// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types, widths and rotate helpers for the ALU issue unit
package alu_pkg;
    localparam int W = 8;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_NOTA, OP_NOTB, OP_OR, OP_AND, OP_XOR, OP_SHL,
        OP_SHR, OP_SRA, OP_ROL, OP_ROR, OP_MULLO, OP_MULHI, OP_PASSA, OP_PASSB
    } alu_op_e;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } alu_flags_t;

    typedef enum logic {IDLE, MUL} state_e;

    function automatic logic [W-1:0] rol(input logic [W-1:0] x, input logic [2:0] s);
        logic [2*W-1:0] t;
        t = {x, x} << s;
        return t[2*W-1:W];
    endfunction

    function automatic logic [W-1:0] ror(input logic [W-1:0] x, input logic [2:0] s);
        logic [2*W-1:0] t;
        t = {x, x} >> s;
        return t[W-1:0];
    endfunction
endpackage

// File: rtl/alu_issue_unit_if.sv
// rtl/alu_issue_unit_if.sv - command and result handshakes of the ALU issue unit
interface alu_issue_unit_if;
    import alu_pkg::*;

    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_res;
    logic [3:0]   out_flags;
    logic         out_err;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_res, out_flags, out_err
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_res, out_flags, out_err
    );
endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational datapath for every single-cycle opcode
module alu_core
    import alu_pkg::*;
(
    input  alu_op_e      op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] res_o,
    output alu_flags_t   flags_o
);
    logic [W:0] sum;
    logic [W:0] diff;
    logic [2:0] sh;
    logic       c;
    logic       v;

    always_comb begin
        sum   = {1'b0, a_i} + {1'b0, b_i};
        diff  = {1'b0, a_i} - {1'b0, b_i};
        sh    = b_i[2:0];
        c     = 1'b0;
        v     = 1'b0;
        res_o = '0;
        case (op_i)
            OP_ADD: begin
                res_o = sum[W-1:0];
                c     = sum[W];
                v     = (a_i[W-1] == b_i[W-1]) && (sum[W-1] != a_i[W-1]);
            end
            OP_SUB: begin
                // carry is "no borrow": set when A >= B unsigned
                res_o = diff[W-1:0];
                c     = ~diff[W];
                v     = (a_i[W-1] != b_i[W-1]) && (diff[W-1] != a_i[W-1]);
            end
            OP_NOTA:  res_o = ~a_i;
            OP_NOTB:  res_o = ~b_i;
            OP_OR:    res_o = a_i | b_i;
            OP_AND:   res_o = a_i & b_i;
            OP_XOR:   res_o = a_i ^ b_i;
            OP_SHL:   res_o = a_i << sh;
            OP_SHR:   res_o = a_i >> sh;
            OP_SRA:   res_o = $signed(a_i) >>> sh;
            OP_ROL:   res_o = rol(a_i, sh);
            OP_ROR:   res_o = ror(a_i, sh);
            OP_MULLO: res_o = '0;
            OP_MULHI: res_o = '0;
            OP_PASSA: res_o = a_i;
            OP_PASSB: res_o = b_i;
        endcase
        flags_o.z = (res_o == '0);
        flags_o.n = res_o[W-1];
        flags_o.c = c;
        flags_o.v = v;
    end
endmodule

// File: rtl/alu_issue_unit.sv
// rtl/alu_issue_unit.sv - issue FSM, shift-add multiplier and result register
// ALU_ISSUE_MUL_EN builds the multiplier; otherwise opcodes 12/13 return out_err.
module alu_issue_unit
    import alu_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    alu_issue_unit_if.slave bus
);
    logic         idle;
    logic         accept;
    logic         is_mul_op;
    logic         single;
    logic         mul_done;
    logic [W-1:0] mul_res;
    logic [W-1:0] core_res;
    alu_flags_t   core_flags;

    logic         valid_q, valid_d;
    logic [W-1:0] res_q, res_d;
    alu_flags_t   flags_q, flags_d;
    logic         err_q, err_d;

    alu_core u_core (
        .op_i    (alu_op_e'(bus.in_op)),
        .a_i     (bus.in_a),
        .b_i     (bus.in_b),
        .res_o   (core_res),
        .flags_o (core_flags)
    );

    assign is_mul_op = (bus.in_op == OP_MULLO) || (bus.in_op == OP_MULHI);
    assign bus.in_ready = idle && (!valid_q || bus.out_ready);
    assign accept = bus.in_valid && bus.in_ready;

`ifdef ALU_ISSUE_MUL_EN
    localparam int MUL_CYCLES = W;

    state_e           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             hi_q, hi_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        mul_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && is_mul_op) begin
                    state_d = MUL;
                    cnt_d   = '0;
                    acc_d   = '0;
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    hi_d    = bus.in_op[0];
                end
            end
            MUL: begin
                // last iteration's partial product feeds the result register directly
                acc_d = acc_q + (b_q[cnt_q] ? ({{W{1'b0}}, a_q} << cnt_q) : '0);
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'(MUL_CYCLES - 1)) begin
                    state_d  = IDLE;
                    mul_done = 1'b1;
                end
            end
        endcase
        mul_res = hi_q ? acc_d[2*W-1:W] : acc_d[W-1:0];
    end

    assign idle   = (state_q == IDLE);
    assign single = !is_mul_op;
`else
    assign idle     = 1'b1;
    assign single   = 1'b1;
    assign mul_done = 1'b0;
    assign mul_res  = '0;
`endif

    always_comb begin
        valid_d = valid_q;
        res_d   = res_q;
        flags_d = flags_q;
        err_d   = err_q;
        if (mul_done) begin
            valid_d   = 1'b1;
            res_d     = mul_res;
            flags_d.z = (mul_res == '0);
            flags_d.n = mul_res[W-1];
            flags_d.c = 1'b0;
            flags_d.v = 1'b0;
            err_d     = 1'b0;
        end else if (accept && single) begin
            valid_d = 1'b1;
            res_d   = core_res;
            flags_d = core_flags;
            err_d   = is_mul_op;
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            err_q   <= err_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_res   = res_q;
    assign bus.out_flags = flags_q;
    assign bus.out_err   = err_q;
endmodule

// File: tb/tb_alu_issue_unit.sv
// tb/tb_alu_issue_unit.sv - directed and random checks of alu_issue_unit against an arithmetic model
module tb_alu_issue_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

`ifdef ALU_ISSUE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    alu_issue_unit_if bus();

    alu_issue_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // returns {err, Z, N, C, V, res[7:0]}
    function automatic int ref_alu(input int op, input int a, input int b);
        int r, sa, sb, s, sh, c, v, err, z, n;
        sa  = (a >= 128) ? a - 256 : a;
        sb  = (b >= 128) ? b - 256 : b;
        sh  = b % 8;
        c   = 0;
        v   = 0;
        err = 0;
        case (op)
            0:  begin r = a + b; c = int'(r > 255); s = sa + sb; v = int'(s > 127 || s < -128); end
            1:  begin r = a - b; c = int'(a >= b);  s = sa - sb; v = int'(s > 127 || s < -128); end
            2:  r = 255 - a;
            3:  r = 255 - b;
            4:  r = a | b;
            5:  r = a & b;
            6:  r = a ^ b;
            7:  r = a << sh;
            8:  r = a >> sh;
            9:  r = sa >>> sh;
            10: r = (a << sh) | (a >> (8 - sh));
            11: r = (a >> sh) | (a << (8 - sh));
            12, 13: begin
                if (MUL_EN) r = (op == 12) ? (a * b) % 256 : (a * b) / 256;
                else begin r = 0; err = 1; end
            end
            14: r = a;
            default: r = b;
        endcase
        r = r & 255;
        z = int'(r == 0);
        n = int'(r >= 128);
        return (err << 12) | (z << 11) | (n << 10) | (c << 9) | (v << 8) | r;
    endfunction

    task automatic drive(input int op, input int a, input int b);
        bus.in_valid = 1'b1;
        bus.in_op    = 4'(op);
        bus.in_a     = 8'(a);
        bus.in_b     = 8'(b);
    endtask

    task automatic check_result(input string tag, input int exp);
        check({tag, "_res"},   32'(bus.out_res),   exp & 255);
        check({tag, "_flags"}, 32'(bus.out_flags), (exp >> 8) & 15);
        check({tag, "_err"},   32'(bus.out_err),   (exp >> 12) & 1);
    endtask

    // issue one command with out_ready=1, check latency, busy span and result
    task automatic run_cmd(input string tag, input int op, input int a, input int b);
        int exp, cyc, busy, lat;
        exp = ref_alu(op, a, b);
        lat = (MUL_EN && (op == 12 || op == 13)) ? 9 : 1;
        bus.out_ready = 1'b1;
        drive(op, a, b);
        cyc = 0;
        while (!bus.in_ready && cyc < 20) begin @(negedge clk); cyc++; end
        check({tag, "_accept"}, 32'(bus.in_ready), 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_a     = 8'($urandom);
        bus.in_b     = 8'($urandom);
        bus.in_op    = 4'($urandom);
        cyc  = 1;
        busy = 0;
        while (!bus.out_valid && cyc < 20) begin
            if (!bus.in_ready) busy++;
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(lat));
        check({tag, "_busy"}, 32'(busy), 32'(lat - 1));
        check_result(tag, exp);
        @(negedge clk);
    endtask

    initial begin
        int op, a, b, exp, seen;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_valid", 32'(bus.out_valid), 0);
        check("rst_res",   32'(bus.out_res),   0);
        check("rst_flags", 32'(bus.out_flags), 0);
        check("rst_err",   32'(bus.out_err),   0);
        check("rst_ready", 32'(bus.in_ready),  1);

        run_cmd("add_ovf", 0, 8'h7F, 8'h01);
        run_cmd("sub_eq",  1, 8'h05, 8'h05);
        run_cmd("sra",     9, 8'h90, 8'h02);
        run_cmd("rol",     10, 8'h81, 8'h01);
        run_cmd("mulhi",   13, 8'hFF, 8'hFF);
        run_cmd("mullo",   12, 8'hFF, 8'hFF);
        run_cmd("sub_brw", 1, 8'h00, 8'h01);
        run_cmd("shl_max", 7, 8'hFF, 8'h07);

        for (int i = 0; i < 30; i++) begin
            run_cmd("rand", int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 255)));
        end

        // back-to-back single-cycle ops, one per cycle
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            op = int'($urandom_range(0, 13));
            if (op >= 12) op += 2;
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            drive(op, a, b);
            check("b2b_ready", 32'(bus.in_ready), 1);
            @(negedge clk);
            check("b2b_valid", 32'(bus.out_valid), 1);
            check_result("b2b", ref_alu(op, a, b));
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("b2b_drain", 32'(bus.out_valid), 0);

        // backpressure: result held, next command stalled until out_ready
        bus.out_ready = 1'b0;
        drive(6, 8'hF0, 8'h3C);
        @(negedge clk);
        a = int'($urandom_range(0, 255));
        b = int'($urandom_range(0, 255));
        drive(0, a, b);
        repeat (3) begin
            check("bp_valid", 32'(bus.out_valid), 1);
            check_result("bp_hold", ref_alu(6, 8'hF0, 8'h3C));
            check("bp_stall", 32'(bus.in_ready), 0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(bus.in_ready), 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp_cont_valid", 32'(bus.out_valid), 1);
        check_result("bp_second", ref_alu(0, a, b));
        @(negedge clk);
        check("bp_drained", 32'(bus.out_valid), 0);

        // reset discards a pending result
        bus.out_ready = 1'b0;
        drive(14, 8'h5A, 8'h00);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("pend_valid", 32'(bus.out_valid), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("pend_rst_valid", 32'(bus.out_valid), 0);
        check("pend_rst_res",   32'(bus.out_res),   0);
        check("pend_rst_flags", 32'(bus.out_flags), 0);
        bus.out_ready = 1'b1;

        // reset during a multiply: no result ever appears
        if (MUL_EN) begin
            drive(13, 8'hFF, 8'hFF);
            @(negedge clk);
            bus.in_valid = 1'b0;
            repeat (3) @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            check("abort_valid", 32'(bus.out_valid), 0);
            check("abort_ready", 32'(bus.in_ready),  1);
            seen = 0;
            repeat (12) begin
                @(negedge clk);
                if (bus.out_valid) seen++;
            end
            check("abort_no_result", 32'(seen), 0);
        end

        exp = ref_alu(15, 0, 8'hA5);
        run_cmd("after_rst", 15, 0, 8'hA5);
        check("after_rst_model_z", 32'((exp >> 11) & 1), 32'(bus.out_res == 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
